// File: rtl/cpu_defs.sv
// Shared CPU definitions: datapath width, canonical NOP and the fetch-entry layout.
package cpu_defs;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- what decode sees whenever there is no valid fetch.
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  // Occupancy encoding of the 2-entry fetch buffer.
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // One buffered fetch: the PC and the instruction word read at it.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_t;

  localparam int FETCH_W = $bits(fetch_t);

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry in-order FIFO with 1-bit wrapping pointers and a flush that
// drops all contents. Entry data is never cleared; only the count decides
// what is visible.
module skid_fifo2 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push_ok, pop_ok;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign push_ok = push_i & (count_q != 2'd2);
  assign pop_ok  = pop_i  & (count_q != 2'd0);

  // Next-state for pointers and count; flush wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_ok) wr_ptr_d = ~wr_ptr_q;
      if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/count registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written only on an accepted push; no reset needed.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i && push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_id_buf.sv
// IF/ID pipeline buffer: a 2-entry fetch FIFO between IROM fetch and decode.
// Adds branch flush, NOP substitution on empty and id_valid masking on top of
// the raw FIFO. if_ready depends only on registered occupancy so the PC stall
// path never loops through decode's ready.
module if_id_buf
  import cpu_defs::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_inst,
  input  logic            if_valid,
  output logic            if_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_inst,
  output logic            id_valid,
  input  logic            id_ready,
  input  logic            flush,
  output logic [1:0]      occupancy
);

  fetch_t               wr_entry;
  fetch_t               head;
  logic [FETCH_W-1:0]   head_raw;
  logic [1:0]           count;
  logic                 push, pop;
  logic [XLEN-1:0]      last_pc_q;

  assign wr_entry = '{pc: if_pc, inst: if_inst};

  // Full blocks fetch even if decode pops this cycle; space shows next cycle.
  assign if_ready = (count != OCC_FULL) & ~rst;
  assign push     = if_valid & if_ready & ~flush;

  // A flushing cycle presents nothing to decode, so nothing is popped either.
  assign id_valid = (count != OCC_EMPTY) & ~flush & ~rst;
  assign pop      = id_valid & id_ready;

  skid_fifo2 #(
    .WIDTH (FETCH_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (head_raw),
    .count_o (count)
  );

  assign head = fetch_t'(head_raw);

  // Remember the last PC shown to decode so id_pc holds across bubbles.
  always_ff @(posedge clk) begin
    if (rst)           last_pc_q <= '0;
    else if (id_valid) last_pc_q <= head.pc;
  end

  assign id_inst   = id_valid ? head.inst : NOP_INST;
  assign id_pc     = rst ? '0 : (id_valid ? head.pc : last_pc_q);
  assign occupancy = count;

endmodule

// File: tb/tb_if_id_buf.sv
// Directed bench for if_id_buf: a driver issues cycle-by-cycle vectors and
// queues the PCs it expects decode to consume; a negedge monitor pops and
// compares whenever decode takes an entry.
module tb_if_id_buf;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = '0;
  logic [31:0] if_inst = '0;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  occupancy;

  int n_chk  = 0;
  int n_fail = 0;
  int n_pop  = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  if_id_buf dut (
    .clk       (clk),
    .rst       (rst),
    .if_pc     (if_pc),
    .if_inst   (if_inst),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .id_pc     (id_pc),
    .id_inst   (id_inst),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .flush     (flush),
    .occupancy (occupancy)
  );

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return pc ^ 32'h1234_5000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: inputs change just after the rising edge, and the
  // task returns at the falling edge where outputs are checked. exp_push
  // records a fetch the bench knows will be accepted; clr drops expectations
  // that a flush or reset in this cycle discards.
  task automatic cyc(input logic r, input logic v, input logic [31:0] pc,
                     input logic rdy, input logic fl, input logic exp_push,
                     input logic clr);
    @(posedge clk);
    #1;
    rst      = r;
    if_valid = v;
    if_pc    = pc;
    if_inst  = mk_inst(pc);
    id_ready = rdy;
    flush    = fl;
    if (clr) exp_q.delete();
    if (exp_push) exp_q.push_back(pc);
    @(negedge clk);
  endtask

  // Monitor: every consumed head must be the oldest outstanding fetch.
  always @(negedge clk) begin
    if (!id_valid) chk("nop_when_invalid", id_inst, NOP);
    if (id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pop: got pc %0h expected no entry at %0t", id_pc, $time);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("id_pc", id_pc, e);
        chk("id_inst", id_inst, mk_inst(e));
        n_pop++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, with garbage fetches offered that must be ignored.
    cyc(1, 1, 32'h100, 1, 0, 0, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_if_ready", if_ready, 0);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_pc", id_pc, 0);
    cyc(1, 1, 32'h104, 1, 1, 0, 0);
    chk("rst_occ2", occupancy, 0);

    // Stream 0x0,0x4,0x8 at full rate.
    cyc(0, 1, 32'h0, 1, 0, 1, 0);
    chk("post_rst_if_ready", if_ready, 1);
    chk("post_rst_occ", occupancy, 0);
    cyc(0, 1, 32'h4, 1, 0, 1, 0);
    chk("stream_occ_a", occupancy, 1);
    chk("stream_valid", id_valid, 1);
    cyc(0, 1, 32'h8, 1, 0, 1, 0);
    chk("stream_occ_b", occupancy, 1);
    cyc(0, 0, 32'h0, 1, 0, 0, 0);
    chk("stream_occ_c", occupancy, 1);
    cyc(0, 0, 32'h0, 1, 0, 0, 0);
    chk("stream_drained", occupancy, 0);

    // Fill with decode stalled, then one pop while full.
    cyc(0, 1, 32'h0, 0, 0, 1, 0);
    cyc(0, 1, 32'h4, 0, 0, 1, 0);
    chk("fill_occ1", occupancy, 1);
    cyc(0, 1, 32'hC, 1, 0, 0, 0);   // offered while full: must be refused
    chk("full_occ", occupancy, 2);
    chk("full_if_ready", if_ready, 0);
    cyc(0, 0, 32'h0, 0, 0, 0, 0);
    chk("after_pop_if_ready", if_ready, 1);
    chk("after_pop_occ", occupancy, 1);

    // Refill to 2, then flush with a concurrent fetch of 0x8.
    cyc(0, 1, 32'h20, 0, 0, 1, 0);
    cyc(0, 1, 32'h8, 1, 1, 0, 1);
    chk("flush_pre_occ", occupancy, 2);
    chk("flush_cycle_valid", id_valid, 0);
    cyc(0, 0, 32'h0, 1, 0, 0, 0);
    chk("flush_occ", occupancy, 0);
    chk("flush_valid", id_valid, 0);
    chk("flush_nop", id_inst, NOP);
    chk("flush_pc_hold", id_pc, 32'h4);

    // Flush at occupancy 1 masks id_valid during the flush cycle.
    cyc(0, 1, 32'h30, 0, 0, 1, 0);
    cyc(0, 0, 32'h0, 1, 1, 0, 1);
    chk("flush1_occ", occupancy, 1);
    chk("flush1_valid", id_valid, 0);
    cyc(0, 0, 32'h0, 1, 1, 0, 0);   // flush on empty
    chk("flush1_after", occupancy, 0);
    cyc(0, 0, 32'h0, 1, 0, 0, 0);
    chk("flush_empty_occ", occupancy, 0);
    chk("flush_empty_valid", id_valid, 0);

    // Reset mid-stream at occupancy 2.
    cyc(0, 1, 32'h40, 0, 0, 1, 0);
    cyc(0, 1, 32'h44, 0, 0, 1, 0);
    cyc(1, 1, 32'h48, 1, 0, 0, 1);
    chk("midrst_if_ready", if_ready, 0);
    chk("midrst_valid", id_valid, 0);
    cyc(1, 0, 32'h0, 1, 0, 0, 0);
    chk("midrst_occ", occupancy, 0);
    chk("midrst_if_ready2", if_ready, 0);
    cyc(0, 0, 32'h0, 1, 0, 0, 0);
    chk("midrst_rel_ready", if_ready, 1);
    chk("midrst_rel_valid", id_valid, 0);
    cyc(0, 0, 32'h0, 1, 0, 0, 0);
    chk("midrst_no_stale", id_valid, 0);

    // Bubbles interleaved with fetches 0x10 and 0x14.
    cyc(0, 0, 32'hDEAD, 1, 0, 0, 0);
    cyc(0, 1, 32'h10, 1, 0, 1, 0);
    cyc(0, 0, 32'hBEEF, 1, 0, 0, 0);
    cyc(0, 0, 32'hBEEF, 1, 0, 0, 0);
    cyc(0, 1, 32'h14, 1, 0, 1, 0);
    cyc(0, 0, 32'hDEAD, 1, 0, 0, 0);
    cyc(0, 0, 32'h0, 1, 0, 0, 0);
    cyc(0, 0, 32'h0, 1, 0, 0, 0);
    chk("bubble_final_occ", occupancy, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    chk("total_pops", n_pop, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_buf.md
IF_ID_BUF -- requirements
Module: if_id_buf

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 if_pc  input  32  PC of the instruction fetched this cycle.
REQ-005 if_inst  input  32  instruction word read from IROM at if_pc.
REQ-006 if_valid  input  1  if_pc/if_inst are a real fetch; low means bubble.
REQ-007 if_ready  output  1  buffer accepts a fetch this cycle; the PC register's stall = ~if_ready.
REQ-008 id_pc  output  32  PC of the head entry presented to decode.
REQ-009 id_inst  output  32  instruction of the head entry; NOP_INST when id_valid is low.
REQ-010 id_valid  output  1  head entry is valid for decode.
REQ-011 id_ready  input  1  decode consumes the head entry this cycle (load-use stall = low).
REQ-012 flush  input  1  taken branch/jump from EX; discard all buffered and incoming fetches.
REQ-013 occupancy  output  2  number of valid entries, 0..2.

Function
REQ-014 Storage SHALL be a 2-entry in-order FIFO of {pc, inst} with 1-bit wr_ptr and rd_ptr, each wrapping 1->0.
REQ-015 Push SHALL occur at a rising edge when if_valid & if_ready & ~flush.
REQ-016 Pop SHALL occur at a rising edge when id_valid & id_ready.
REQ-017 if_ready SHALL be (occupancy != 2) & ~rst, from registered state only; it SHALL NOT depend on id_ready.
REQ-018 When full, a simultaneous pop SHALL NOT permit a same-cycle push; if_ready rises the cycle after the pop.
REQ-019 Simultaneous push and pop at occupancy 1 SHALL leave occupancy at 1 and advance both pointers.
REQ-020 Latency SHALL be one cycle: a fetch pushed at edge N is visible on id_* after edge N when the buffer was empty.
REQ-021 Sustained if_valid=1, id_ready=1 SHALL give one instruction per cycle with occupancy held at 1.
REQ-022 id_valid SHALL be (occupancy != 0) & ~flush; id_pc and id_inst SHALL come from entry[rd_ptr].
REQ-023 When id_valid is low, id_inst SHALL be NOP_INST (0x00000013) and id_pc SHALL hold its last value.
REQ-024 Flush SHALL clear occupancy and reset both pointers to 0 at the next edge; the concurrent push and pop SHALL be discarded.
REQ-025 Flush SHALL take priority over every other event in the same cycle.
REQ-026 Flush on an empty buffer SHALL be harmless, with the buffer remaining empty.
REQ-027 Push with if_valid=0 SHALL NOT occur; bubbles are never stored.

Reset
REQ-028 While rst is high at an edge: occupancy=0, wr_ptr=rd_ptr=0, id_valid=0, id_inst=NOP_INST, id_pc=0, if_ready=0.
REQ-029 On the first cycle after rst falls, if_ready SHALL be 1, so the post-reset fetch at PC 0x00000000 is accepted.
REQ-030 Reset SHALL override flush, push and pop; entry data need not be cleared, but SHALL NOT be observable.

Structure
REQ-031 NOP_INST (32'h00000013) and XLEN (32) SHALL live in the shared cpu_defs package.
REQ-032 The FIFO storage and pointers SHALL be a sub-module skid_fifo2 (parameter WIDTH=64); if_id_buf adds flush, NOP substitution and id_valid masking.

Verification
REQ-033 Reset then stream PCs 0x0,0x4,0x8 with id_ready=1: id_pc SHALL show 0x0,0x4,0x8 on consecutive cycles and occupancy SHALL stay 1.
REQ-034 Push 0x0 and 0x4 with id_ready=0: occupancy SHALL be 2 and if_ready 0; id_ready=1 for one cycle pops 0x0, and if_ready SHALL return to 1 the next cycle.
REQ-035 Occupancy 2 plus flush=1 with if_valid=1 (PC 0x8): the next cycle SHALL show occupancy 0, id_valid 0 and id_inst 0x00000013, and PC 0x8 SHALL never appear.
REQ-036 id_valid SHALL be 0 during the flush cycle itself, even with occupancy 1.
REQ-037 Assert rst mid-stream at occupancy 2: the next cycle SHALL show occupancy 0 and if_ready 0, and no stale entry SHALL emerge after release.
REQ-038 Apply if_valid=0 bubbles interleaved with fetches 0x10,0x14: only 0x10 and 0x14 SHALL reach id_*, in order.
